// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and constants for the repeated-addition
//                multiplier and its operand feeder.
//  Revision    : 1.0  initial release
// ============================================================================
package mul_pkg;

    // Operand, bus and product width shared with the multiplier data path.
    localparam int MUL_WIDTH = 16;

    // Feeder sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DRV_A = 3'd2,
        ST_DRV_B = 3'd3,
        ST_WAIT  = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : mul_timeout_cnt
//  Description : Wait-cycle counter with a terminal-count flag. The count
//                saturates at TIMEOUT-1 so it can never wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_timeout_cnt #(
    parameter int TO_W    = 17,
    parameter int TIMEOUT = 70000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    output logic [TO_W-1:0] count,
    output logic            expired
);

    localparam logic [TO_W-1:0] c_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] r_count;

    // Clear takes priority; otherwise count up while enabled, holding at the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LAST)) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    assign count   = r_count;
    assign expired = (r_count == c_LAST);

endmodule : mul_timeout_cnt
`default_nettype wire

// File: rtl/mul_operand_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : mul_operand_feeder
//  Description : Accepts an operand pair, pulses the multiplier start, drives
//                A then B on the shared bus, waits for done with a timeout
//                and hands the captured product downstream.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_operand_feeder
    import mul_pkg::*;
#(
    parameter int WIDTH   = MUL_WIDTH,
    parameter int TO_W    = 17,
    parameter int TIMEOUT = 70000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] bus,
    output logic             start,
    input  logic             done,
    input  logic [WIDTH-1:0] product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_product,
    output logic             out_timeout,
    output logic [TO_W-1:0]  out_cycles,
    output logic             busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_op_a;
    logic [WIDTH-1:0]  r_op_b;
    logic [WIDTH-1:0]  r_out_product;
    logic              r_out_timeout;
    logic [TO_W-1:0]   r_out_cycles;
    logic [TO_W-1:0]   w_cnt;
    logic              w_expired;
    logic              w_accept;
    logic              w_cnt_clear;
    logic              w_cnt_en;

    // A pending done from the multiplier blocks acceptance so a stale level
    // cannot be mistaken for completion of the next job.
    assign w_accept    = (r_state == ST_IDLE) && in_valid && !done;
    assign w_cnt_clear = (r_state == ST_DRV_B);
    assign w_cnt_en    = (r_state == ST_WAIT);

    mul_timeout_cnt #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_cnt_clear),
        .enable  (w_cnt_en),
        .count   (w_cnt),
        .expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state sequencing: fixed three-cycle operand phase, then wait and hold.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_DRV_A;
            ST_DRV_A: w_state_nxt = ST_DRV_B;
            ST_DRV_B: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (done || w_expired) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latches and result capture; done wins over a coincident timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_out_product <= '0;
            r_out_timeout <= 1'b0;
            r_out_cycles  <= '0;
        end else begin
            if (w_accept) begin
                r_op_a <= in_a;
                r_op_b <= in_b;
            end
            if (r_state == ST_WAIT) begin
                if (done) begin
                    r_out_product <= product;
                    r_out_timeout <= 1'b0;
                    r_out_cycles  <= w_cnt + TO_W'(1);
                end else if (w_expired) begin
                    r_out_product <= '0;
                    r_out_timeout <= 1'b1;
                    r_out_cycles  <= TO_W'(TIMEOUT);
                end
            end
        end
    end

    // Moore output decodes; in_ready is the only path combinational on an input.
    always_comb begin
        bus = '0;
        case (r_state)
            ST_START, ST_DRV_A: bus = r_op_a;
            ST_DRV_B, ST_WAIT:  bus = r_op_b;
            default:            bus = '0;
        endcase
    end

    assign start       = (r_state == ST_START);
    assign in_ready    = (r_state == ST_IDLE) && !done;
    assign out_valid   = (r_state == ST_HOLD);
    assign busy        = (r_state != ST_IDLE);
    assign out_product = r_out_product;
    assign out_timeout = r_out_timeout;
    assign out_cycles  = r_out_cycles;

endmodule : mul_operand_feeder
`default_nettype wire

// File: doc/mul_operand_feeder.md
Name: mul_operand_feeder

Overview:
- Upstream sequencer for the repeated-addition multiplier (control/data path pair on a shared 16-bit operand bus).
- Accepts an operand pair over a valid/ready handshake and pulses the multiplier's `start`.
- Drives A, then B, onto the shared bus on the exact edges the multiplier samples them.
- Waits for `done` with a timeout, captures the product, and presents it downstream over valid/ready.

Parameters:
- WIDTH, 16, operand/bus/product width.
- TO_W, 17, width of the wait/timeout cycle counter.
- TIMEOUT, 70000, maximum cycles spent in WAIT before aborting; legal range 2..2^TO_W-1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  feeder can accept a pair.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier (iteration count).
- bus  out  WIDTH  shared operand bus to the multiplier.
- start  out  1  one-cycle start pulse to the multiplier.
- done  in  1  multiplier done level.
- product  in  WIDTH  multiplier product register value.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_product  out  WIDTH  captured product (0 on timeout).
- out_timeout  out  1  result is a timeout abort.
- out_cycles  out  TO_W  cycles spent in WAIT for this job.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Outputs: start=0, bus=0, out_valid=0, out_product=0, out_timeout=0, out_cycles=0, busy=0.
  - Operand latches cleared.
  - Takes effect immediately, including mid-operation.
- States: IDLE, START, DRV_A, DRV_B, WAIT, HOLD. Moore decodes of the state register.
- The only input→output combinational path is `done` → `in_ready`.
- IDLE:
  - in_ready = !done; bus=0.
  - On in_valid && in_ready: latch in_a/in_b, go to START.
  - in_valid with done=1 is ignored (no accept, no start).
- START:
  - start=1 for exactly this one cycle; bus=A.
  - Next state DRV_A.
- DRV_A:
  - bus=A. The multiplier samples A on this cycle's closing edge (the first edge after it sampled start).
  - Next state DRV_B.
- DRV_B:
  - bus=B. Sampled on the second edge after start.
  - Next state WAIT; the cycle counter is cleared to 0 on this transition.
- WAIT:
  - bus holds B; the counter increments each cycle.
  - On the first edge with done=1:
    - out_product <= product, out_timeout <= 0, out_cycles <= counter+1.
    - out_valid <= 1, go to HOLD.
  - Else if counter == TIMEOUT-1:
    - out_product <= 0, out_timeout <= 1, out_cycles <= TIMEOUT.
    - out_valid <= 1, go to HOLD.
  - done and timeout on the same edge: done wins (product captured, out_timeout=0).
- HOLD:
  - out_valid=1; out_product/out_timeout/out_cycles stable until the handshake.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE.
  - No bypass: a new pair is accepted no earlier than the cycle after the result handshake.
- in_ready = 0 in every state except IDLE; in_valid outside IDLE is ignored.
- Arithmetic:
  - Counter is unsigned TO_W and never wraps (bounded by TIMEOUT).
  - Product is passed through unmodified; no overflow detection.
- Latency: accept edge → start high for 1 cycle → A → B → WAIT. Minimum accept-to-out_valid is 4 cycles plus the multiplier's time to assert done.

Decomposition:
- Shared package mul_pkg:
  - state enumeration: IDLE, START, DRV_A, DRV_B, WAIT, HOLD.
  - default WIDTH constant (16), shared with the multiplier data path.
- One sub-module: mul_timeout_cnt.
  - Inputs: clear, enable.
  - Outputs: TO_W-bit count and expired flag (count == TIMEOUT-1).
  - Parameterised by TO_W/TIMEOUT.

Test Plan:
1. Accept a=3, b=5 when idle.
   -> start=1 exactly one cycle, the cycle after accept.
   -> bus=3 for the START/DRV_A cycles, bus=5 in DRV_B.
   -> Model asserts done with product=15 on the 6th WAIT cycle.
   -> out_valid=1, out_product=15, out_timeout=0, out_cycles=6.
2. Result pending with out_ready=0 for 10 cycles.
   -> out_valid held, outputs stable, in_ready=0.
   -> Then out_ready=1 -> out_valid=0 the next cycle, in_ready=1.
3. TIMEOUT=20, done never asserted.
   -> out_valid after exactly 20 WAIT cycles, out_timeout=1, out_product=0, out_cycles=20.
4. TIMEOUT=20, done first asserted on the 20th WAIT cycle with product=0x1234.
   -> out_timeout=0, out_product=0x1234.
5. done held high while IDLE, in_valid=1 with a=7, b=2.
   -> in_ready=0, no start pulse, bus=0, state stays IDLE.
   -> After done drops, the pair is accepted.
6. rst_n pulsed low during WAIT.
   -> start=0, bus=0, out_valid=0, busy=0 immediately.
   -> After release, in_ready=1 and a new job (a=2, b=4, product=8) completes normally.
